// File: rtl/shift_deserializer.sv
// shift_deserializer: rebuilds WIDTH-bit words from a serial stream (MSB- or LSB-first)
// and holds each completed word in a one-entry valid/ready output buffer.
module shift_deserializer #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             dir,
  input  logic             sync_clr,
  input  logic             par_ready,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, par_q, par_d, base, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d, pv_q, pv_d, ovr_q, ovr_d;
  logic accept, cur_dir, last, xfer;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      par_q   <= '0;
      pv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      par_q   <= par_d;
      pv_q    <= pv_d;
      ovr_q   <= ovr_d;
    end

  // The first bit of a word takes dir live and starts from a clean register.
  always_comb begin
    accept  = enable & ser_valid & ~sync_clr;
    cur_dir = (state_q == IDLE) ? dir : dir_q;
    base    = (state_q == IDLE) ? '0 : sh_q;
    shifted = cur_dir ? {ser_in, base[WIDTH-1:1]} : {base[WIDTH-2:0], ser_in};
    last    = accept && (cnt_q == CNT_W'(WIDTH - 1));
    xfer    = pv_q & par_ready;
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    par_d   = par_q;
    pv_d    = pv_q & ~xfer;
    ovr_d   = ovr_q;
    if (sync_clr) begin
      state_d = IDLE;
      sh_d    = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (accept) begin
      sh_d    = shifted;
      dir_d   = cur_dir;
      cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
      state_d = last ? IDLE : COLLECT;
    end
    if (last) begin
      if (!pv_q || par_ready) begin
        par_d = shifted;
        pv_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign par_out   = par_q;
  assign par_valid = pv_q;
  assign bit_cnt   = cnt_q;
  assign overrun   = ovr_q;
endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer: directed tests of the WIDTH=4 deserializer.
module tb_shift_deserializer;
  logic clock = 1'b0, reset_n = 1'b0, enable = 1'b0, ser_in = 1'b0, ser_valid = 1'b0;
  logic dir = 1'b0, sync_clr = 1'b0, par_ready = 1'b0;
  logic [3:0] par_out;
  logic par_valid, overrun;
  logic [2:0] bit_cnt;
  int checks = 0, errors = 0;
  logic mon_en = 1'b0;
  logic [3:0] got[$];

  shift_deserializer #(.WIDTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .ser_in(ser_in),
    .ser_valid(ser_valid), .dir(dir), .sync_clr(sync_clr), .par_ready(par_ready),
    .par_out(par_out), .par_valid(par_valid), .bit_cnt(bit_cnt), .overrun(overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (mon_en && par_valid && par_ready) got.push_back(par_out);

  task automatic send_bit(input logic b);
    enable = 1'b1; ser_valid = 1'b1; ser_in = b;
    @(posedge clock); #1;
    ser_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [3:0] b);
    for (int i = 3; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain;
    par_ready = 1'b1; idle(1); par_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (par_out !== 4'b0000) begin errors++; $display("FAIL reset_par_out got=%b exp=0000", par_out); end
    checks++; if (par_valid !== 1'b0) begin errors++; $display("FAIL reset_par_valid got=%b exp=0", par_valid); end
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_msb_first;
    dir = 1'b0;
    send_bit(1); send_bit(1); send_bit(0);
    checks++; if (bit_cnt !== 3'd3) begin errors++; $display("FAIL msb_cnt3 got=%0d exp=3", bit_cnt); end
    checks++; if (par_valid !== 1'b0) begin errors++; $display("FAIL msb_early_valid got=%b exp=0", par_valid); end
    send_bit(0);
    checks++; if (par_out !== 4'b1100) begin errors++; $display("FAIL msb_word got=%b exp=1100", par_out); end
    checks++; if (par_valid !== 1'b1) begin errors++; $display("FAIL msb_valid got=%b exp=1", par_valid); end
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL msb_cnt0 got=%0d exp=0", bit_cnt); end
    idle(2);
    checks++; if (par_valid !== 1'b1 || par_out !== 4'b1100) begin errors++; $display("FAIL msb_hold got=%b/%b exp=1/1100", par_valid, par_out); end
    drain();
    checks++; if (par_valid !== 1'b0) begin errors++; $display("FAIL msb_consumed got=%b exp=0", par_valid); end
  endtask

  task automatic test_lsb_first;
    dir = 1'b1;
    send_bits(4'b1100);
    checks++; if (par_out !== 4'b0011) begin errors++; $display("FAIL lsb_word got=%b exp=0011", par_out); end
    drain();
    send_bit(1); send_bit(1);
    dir = 1'b0;
    send_bit(0); send_bit(0);
    checks++; if (par_out !== 4'b0011) begin errors++; $display("FAIL lsb_dir_toggle got=%b exp=0011", par_out); end
    drain();
  endtask

  task automatic test_overrun;
    dir = 1'b0;
    send_bits(4'b0110);
    send_bits(4'b1001);
    checks++; if (par_out !== 4'b0110) begin errors++; $display("FAIL ovr_kept got=%b exp=0110", par_out); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    sync_clr = 1'b1; idle(1); sync_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
    checks++; if (par_valid !== 1'b1 || par_out !== 4'b0110) begin errors++; $display("FAIL ovr_clr_keeps got=%b/%b exp=1/0110", par_valid, par_out); end
    drain();
  endtask

  task automatic test_back_to_back;
    got.delete();
    mon_en = 1'b1; par_ready = 1'b1;
    send_bits(4'b0001); send_bits(4'b0010); send_bits(4'b0100);
    idle(2);
    mon_en = 1'b0; par_ready = 1'b0;
    checks++; if (got.size() != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
    else begin
      checks++; if (got[0] !== 4'b0001 || got[1] !== 4'b0010 || got[2] !== 4'b0100) begin errors++; $display("FAIL b2b_order got=%b,%b,%b exp=0001,0010,0100", got[0], got[1], got[2]); end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    send_bits(4'b0101);
    send_bit(1); send_bit(0); send_bit(1);
    par_ready = 1'b1;
    send_bit(0);
    par_ready = 1'b0;
    checks++; if (par_valid !== 1'b1 || par_out !== 4'b1010) begin errors++; $display("FAIL same_edge got=%b/%b exp=1/1010", par_valid, par_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL same_edge_ovr got=%b exp=0", overrun); end
    drain();
  endtask

  task automatic test_enable_hold;
    send_bit(1); send_bit(0);
    enable = 1'b0; ser_valid = 1'b1; ser_in = 1'b0;
    idle(5);
    ser_valid = 1'b0;
    checks++; if (bit_cnt !== 3'd2 || par_valid !== 1'b0) begin errors++; $display("FAIL en_hold got=%0d/%b exp=2/0", bit_cnt, par_valid); end
    send_bit(1); send_bit(1);
    checks++; if (par_out !== 4'b1011 || par_valid !== 1'b1) begin errors++; $display("FAIL en_word got=%b/%b exp=1011/1", par_out, par_valid); end
    enable = 1'b0;
    drain();
    checks++; if (par_valid !== 1'b0) begin errors++; $display("FAIL en_handshake got=%b exp=0", par_valid); end
  endtask

  task automatic test_sync_clr_reset;
    send_bit(1); send_bit(1); send_bit(1);
    enable = 1'b1; ser_valid = 1'b1; ser_in = 1'b1; sync_clr = 1'b1;
    idle(1);
    ser_valid = 1'b0; sync_clr = 1'b0;
    checks++; if (bit_cnt !== 3'd0 || par_valid !== 1'b0) begin errors++; $display("FAIL clr_cnt got=%0d/%b exp=0/0", bit_cnt, par_valid); end
    send_bits(4'b1010);
    checks++; if (par_out !== 4'b1010 || par_valid !== 1'b1) begin errors++; $display("FAIL clr_word got=%b/%b exp=1010/1", par_out, par_valid); end
    send_bit(1); send_bit(1);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (par_out !== 4'b0000 || par_valid !== 1'b0 || bit_cnt !== 3'd0 || overrun !== 1'b0) begin errors++; $display("FAIL async_reset got=%b/%b/%0d/%b exp=0000/0/0/0", par_out, par_valid, bit_cnt, overrun); end
    reset_n = 1'b1;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_enable_hold();
    test_sync_clr_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
